// File: rtl/dut_result_readback.sv
// dut_result_readback: samples z after a fixed strobe latency into a FIFO and streams each sample as an A5/seq/data byte frame
module dut_result_readback #(
  parameter int Z_WIDTH = 72,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strobe,
  input  logic [Z_WIDTH-1:0]     z,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int NB = (Z_WIDTH + 7) / 8;
  localparam int SW = 8 * NB;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [2:0] {IDLE, HDR, SEQ, DATA, END} state_t;
  state_t state;
  logic cap, full, pop, push;
  logic [7:0] seq, fseq;
  logic [AW-1:0] wr, rd;
  logic [IW-1:0] idx;
  logic [SW-1:0] sh;
  logic [Z_WIDTH+7:0] mem [DEPTH];
  generate
    if (LATENCY == 0) begin : g_comb
      assign cap = strobe;
    end else begin : g_dly
      logic [LATENCY-1:0] dly;
      always_ff @(posedge clk or posedge rst)
        if (rst) dly <= '0;
        else dly <= LATENCY'({dly, strobe});
      assign cap = dly[LATENCY-1];
    end
  endgenerate
  assign full = fifo_count == (AW+1)'(DEPTH);
  // END also launches the next frame so back-to-back frames are split by exactly one idle cycle
  assign pop  = (state == IDLE || state == END) && fifo_count != '0;
  assign push = cap && (!full || pop);
  always_ff @(posedge clk)
    if (push) mem[wr] <= {seq, z};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      overflow   <= 1'b0;
      fifo_count <= '0;
      seq        <= '0;
      fseq       <= '0;
      wr         <= '0;
      rd         <= '0;
      idx        <= '0;
      sh         <= '0;
    end else begin
      if (cap) seq <= seq + 8'd1;
      if (cap && full && !pop) overflow <= 1'b1;
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      fifo_count <= fifo_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      case (state)
        IDLE, END: begin
          tx_valid <= pop;
          state    <= pop ? HDR : IDLE;
          if (pop) begin
            tx_data <= 8'hA5;
            fseq    <= mem[rd][Z_WIDTH +: 8];
            sh      <= SW'(mem[rd][Z_WIDTH-1:0]);
          end
        end
        HDR: if (tx_ready) begin
          tx_data <= fseq;
          state   <= SEQ;
        end
        SEQ: if (tx_ready) begin
          tx_data <= sh[7:0];
          sh      <= sh >> 8;
          idx     <= '0;
          state   <= DATA;
        end
        DATA: if (tx_ready) begin
          if (idx == IW'(NB - 1)) begin
            tx_valid <= 1'b0;
            state    <= END;
          end else begin
            idx     <= idx + 1'b1;
            tx_data <= sh[7:0];
            sh      <= sh >> 8;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dut_result_readback.sv
// tb_dut_result_readback: randomized and directed checks of the readback framer against a frame-queue reference model
module tb_dut_result_readback;
  localparam int Z_WIDTH = 72;
  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;
  localparam int NB      = (Z_WIDTH + 7) / 8;
  localparam int FL      = NB + 2;
  logic clk = 1'b0, rst = 1'b1, strobe = 1'b0, tx_ready = 1'b0;
  logic [Z_WIDTH-1:0] z = '0;
  logic [7:0] tx_data;
  logic tx_valid, overflow;
  logic [$clog2(DEPTH):0] fifo_count;
  int n_checks = 0, n_errors = 0;
  dut_result_readback #(.Z_WIDTH(Z_WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .z(z), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .overflow(overflow), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  typedef struct { logic [7:0] s; logic [Z_WIDTH-1:0] d; } item_t;
  item_t q[$];
  logic [7:0] fb[$];
  logic [7:0] rx[$];
  bit m_valid, m_ovf;
  logic [7:0] m_seq;
  bit hist[16];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: accepted captures wait in q; a frame is launched whenever the stream is idle and q holds something
  always @(posedge clk or posedge rst) begin
    bit cap, pop;
    int n;
    item_t it;
    logic [8*NB-1:0] zx;
    if (rst) begin
      q.delete();
      fb.delete();
      m_valid = 0;
      m_ovf = 0;
      m_seq = 0;
      foreach (hist[i]) hist[i] = 0;
    end else begin
      cap = LATENCY == 0 ? strobe : hist[(LATENCY > 0) ? LATENCY-1 : 0];
      for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = strobe;
      n = q.size();
      pop = !m_valid && n > 0;
      if (m_valid && tx_ready) begin
        void'(fb.pop_front());
        if (fb.size() == 0) m_valid = 0;
      end
      if (pop) begin
        it = q.pop_front();
        zx = (8*NB)'(it.d);
        fb.push_back(8'hA5);
        fb.push_back(it.s);
        for (int i = 0; i < NB; i++) fb.push_back(zx[8*i +: 8]);
        m_valid = 1;
      end
      if (cap) begin
        if (n < DEPTH || pop) q.push_back('{m_seq, z});
        else m_ovf = 1;
        m_seq++;
      end
    end
  end
  always @(negedge clk) if (!rst) begin
    chk("tx_valid", 64'(tx_valid), 64'(m_valid));
    if (m_valid && fb.size() > 0) chk("tx_data", 64'(tx_data), 64'(fb[0]));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("fifo_count", 64'(fifo_count), 64'(q.size()));
    if (tx_valid && tx_ready) rx.push_back(tx_data);
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask
  function automatic logic [Z_WIDTH-1:0] rz();
    return Z_WIDTH'({$urandom, $urandom, $urandom});
  endfunction
  logic [7:0] exp1 [FL];
  initial begin
    exp1 = '{8'hA5, 8'h00, 8'h55, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    tick(2);
    chk("reset tx_valid", 64'(tx_valid), 64'd0);
    chk("reset tx_data", 64'(tx_data), 64'd0);
    chk("reset fifo_count", 64'(fifo_count), 64'd0);
    rst = 1'b0;
    tx_ready = 1'b1;
    tick(8);
    // single frame; z differs on neighbouring cycles of the capture cycle
    rx.delete();
    strobe = 1'b1;
    z = rz();
    tick();
    strobe = 1'b0;
    z = rz();
    tick();
    z = 72'h0123456789ABCDEF55;
    tick();
    z = rz();
    tick();
    z = rz();
    tick(20);
    chk("frame1 len", 64'(rx.size()), 64'(FL));
    for (int i = 0; i < FL && i < rx.size(); i++) chk($sformatf("frame1 byte%0d", i), 64'(rx[i]), 64'(exp1[i]));
    // overflow: six strobes while stalled
    do_reset();
    rx.delete();
    tx_ready = 1'b0;
    strobe = 1'b1;
    tick(6);
    strobe = 1'b0;
    tick(4);
    chk("ovf sticky", 64'(overflow), 64'd1);
    chk("ovf count", 64'(fifo_count), 64'd4);
    tx_ready = 1'b1;
    tick(70);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(20);
    chk("ovf rx len", 64'(rx.size()), 64'(6*FL));
    begin
      logic [7:0] es [6];
      es = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
      for (int k = 0; k < 6; k++)
        if (1 + k*FL < rx.size()) chk($sformatf("ovf seq%0d", k), 64'(rx[1 + k*FL]), 64'(es[k]));
    end
    chk("ovf still sticky", 64'(overflow), 64'd1);
    // full FIFO, launch slot coincides with a capture
    do_reset();
    rx.delete();
    tx_ready = 1'b0;
    strobe = 1'b1;
    tick(5);
    strobe = 1'b0;
    tick(5);
    chk("full count", 64'(fifo_count), 64'd4);
    tx_ready = 1'b1;
    tick(9);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(2);
    chk("full+pop count", 64'(fifo_count), 64'd4);
    chk("full+pop ovf", 64'(overflow), 64'd0);
    tick(70);
    chk("full+pop rx len", 64'(rx.size()), 64'(6*FL));
    // reset while byte 5 of a frame is stalled
    do_reset();
    rx.delete();
    tx_ready = 1'b0;
    strobe = 1'b1;
    tick(2);
    strobe = 1'b0;
    tick(4);
    tx_ready = 1'b1;
    tick(5);
    tx_ready = 1'b0;
    tick(2);
    chk("pre-rst rx len", 64'(rx.size()), 64'd5);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst tx_valid", 64'(tx_valid), 64'd0);
    chk("mid-rst fifo_count", 64'(fifo_count), 64'd0);
    tick(2);
    rst = 1'b0;
    rx.delete();
    tx_ready = 1'b1;
    tick(3);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick(20);
    chk("post-rst rx len", 64'(rx.size()), 64'(FL));
    if (rx.size() > 1) begin
      chk("post-rst hdr", 64'(rx[0]), 64'hA5);
      chk("post-rst seq", 64'(rx[1]), 64'h00);
    end
    // randomized traffic with stalls
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      strobe = $urandom_range(0, 3) == 0;
      tx_ready = (c / 200) % 4 == 3 ? 1'b0 : $urandom_range(0, 2) != 0;
      z = rz();
      tick();
    end
    strobe = 1'b0;
    tx_ready = 1'b1;
    tick(80);
    chk("drain fifo_count", 64'(fifo_count), 64'd0);
    chk("drain tx_valid", 64'(tx_valid), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
